// File: rtl/hand_gesture_decoder.sv
// hand_gesture_decoder: turns a stream of tracked hand coordinates into
// one-cycle swipe pulses (left/right/up/down).
// Optional feature macro: DEPTH_GATE_EN -- when defined, samples with
// hand_z_in > Z_MAX are treated as invalid (no anchor in IDLE, abort in TRACK).
module hand_gesture_decoder #(
   parameter int unsigned SWIPE_THRESH    = 200,
   parameter int unsigned WINDOW_SAMPLES  = 8,
   parameter int unsigned COOLDOWN_CYCLES = 1_000_000,
   parameter logic [13:0] Z_MAX           = 14'd4000
) (
   input  logic        clk_in,
   input  logic        rst_in,
   input  logic        pos_valid_in,
   input  logic [11:0] hand_x_in,
   input  logic [11:0] hand_y_in,
   input  logic [13:0] hand_z_in,
   output logic        swipe_left_out,
   output logic        swipe_right_out,
   output logic        swipe_up_out,
   output logic        swipe_down_out,
   output logic        busy_out
);

   localparam int unsigned CNT_W = (WINDOW_SAMPLES > 2) ? $clog2(WINDOW_SAMPLES) : 1;
   localparam int unsigned CD_W  = (COOLDOWN_CYCLES > 2) ? $clog2(COOLDOWN_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WINDOW_SAMPLES - 1);
   localparam logic [CD_W-1:0]  CD_LAST  = CD_W'(COOLDOWN_CYCLES - 1);
   localparam logic [11:0]      THRESH   = 12'(SWIPE_THRESH);

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      TRACK    = 2'd1,
      COOLDOWN = 2'd2
   } state_t;

   state_t           state;
   logic [11:0]      anchor_x;
   logic [11:0]      anchor_y;
   logic [CNT_W-1:0] count;
   logic [CD_W-1:0]  cd_count;

   logic signed [12:0] dx;
   logic signed [12:0] dy;
   logic [11:0]        abs_dx;
   logic [11:0]        abs_dy;
   logic               hit_h;
   logic               hit_v;
   logic [CNT_W-1:0]   count_inc;
   logic               z_ok;

`ifdef DEPTH_GATE_EN
   // Far samples are rejected outright
   assign z_ok = (hand_z_in <= Z_MAX);
`else
   logic unused_z;
   assign unused_z = ^hand_z_in;
   assign z_ok     = 1'b1;
`endif

   // Displacement from anchor and swipe classification (horizontal wins ties)
   always_comb begin
      dx        = 13'({1'b0, hand_x_in}) - 13'({1'b0, anchor_x});
      dy        = 13'({1'b0, hand_y_in}) - 13'({1'b0, anchor_y});
      abs_dx    = dx[12] ? 12'(-dx) : dx[11:0];
      abs_dy    = dy[12] ? 12'(-dy) : dy[11:0];
      hit_h     = (abs_dx >= THRESH) && (abs_dx >= abs_dy);
      hit_v     = !hit_h && (abs_dy >= THRESH);
      count_inc = count + CNT_W'(1);
   end

   // Gesture FSM with registered one-cycle pulses and busy flag
   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         state           <= IDLE;
         anchor_x        <= '0;
         anchor_y        <= '0;
         count           <= '0;
         cd_count        <= '0;
         swipe_left_out  <= 1'b0;
         swipe_right_out <= 1'b0;
         swipe_up_out    <= 1'b0;
         swipe_down_out  <= 1'b0;
         busy_out        <= 1'b0;
      end else begin
         swipe_left_out  <= 1'b0;
         swipe_right_out <= 1'b0;
         swipe_up_out    <= 1'b0;
         swipe_down_out  <= 1'b0;
         case (state)
            IDLE: begin
               if (pos_valid_in && z_ok) begin
                  anchor_x <= hand_x_in;
                  anchor_y <= hand_y_in;
                  count    <= '0;
                  state    <= TRACK;
                  busy_out <= 1'b1;
               end
            end
            TRACK: begin
               if (pos_valid_in) begin
                  if (!z_ok) begin
                     count    <= '0;
                     state    <= IDLE;
                     busy_out <= 1'b0;
                  end else if (hit_h) begin
                     swipe_left_out  <= dx[12];
                     swipe_right_out <= !dx[12] && (dx != 13'sd0);
                     cd_count        <= '0;
                     state           <= COOLDOWN;
                  end else if (hit_v) begin
                     swipe_up_out   <= dy[12];
                     swipe_down_out <= !dy[12] && (dy != 13'sd0);
                     cd_count       <= '0;
                     state          <= COOLDOWN;
                  end else if (count_inc == CNT_LAST) begin
                     // Window exhausted without a swipe: restart from here
                     anchor_x <= hand_x_in;
                     anchor_y <= hand_y_in;
                     count    <= '0;
                  end else begin
                     count <= count_inc;
                  end
               end
            end
            COOLDOWN: begin
               if (cd_count == CD_LAST) begin
                  cd_count <= '0;
                  count    <= '0;
                  state    <= IDLE;
                  busy_out <= 1'b0;
               end else begin
                  cd_count <= cd_count + CD_W'(1);
               end
            end
            default: begin
               state    <= IDLE;
               busy_out <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_hand_gesture_decoder.sv
// Directed self-checking bench for hand_gesture_decoder (COOLDOWN_CYCLES=16).
module tb_hand_gesture_decoder;

   logic        clk;
   logic        rst;
   logic        valid;
   logic [11:0] hx;
   logic [11:0] hy;
   logic [13:0] hz;
   logic        left, right, up, down, busy;
   logic [3:0]  pulses;

   int n_cmp;
   int n_bad;

   localparam logic [3:0] P_NONE  = 4'b0000;
   localparam logic [3:0] P_LEFT  = 4'b1000;
   localparam logic [3:0] P_RIGHT = 4'b0100;
   localparam logic [3:0] P_UP    = 4'b0010;
   localparam logic [3:0] P_DOWN  = 4'b0001;

   hand_gesture_decoder #(.COOLDOWN_CYCLES(16)) dut (
      .clk_in         (clk),
      .rst_in         (rst),
      .pos_valid_in   (valid),
      .hand_x_in      (hx),
      .hand_y_in      (hy),
      .hand_z_in      (hz),
      .swipe_left_out (left),
      .swipe_right_out(right),
      .swipe_up_out   (up),
      .swipe_down_out (down),
      .busy_out       (busy)
   );

   assign pulses = {left, right, up, down};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Count one comparison and report a mismatch
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
      end
   endtask

   // Present one sample for one clock; returns #1 after the capturing edge
   task automatic send(input int x, input int y, input int z);
      @(negedge clk);
      valid = 1'b1;
      hx    = 12'(x);
      hy    = 12'(y);
      hz    = 14'(z);
      @(posedge clk);
      #1;
      valid = 1'b0;
   endtask

   // Wait (bounded) for busy to drop; report cycles taken and any pulses seen
   task automatic wait_idle(output int n, output logic [3:0] seen);
      n    = 0;
      seen = 4'b0;
      while (busy && n < 100) begin
         @(posedge clk);
         #1;
         n++;
         seen = seen | pulses;
      end
   endtask

   int         n;
   logic [3:0] seen;

   initial begin
      n_cmp = 0;
      n_bad = 0;
      rst   = 1'b1;
      valid = 1'b0;
      hx    = '0;
      hy    = '0;
      hz    = 14'd1000;
      repeat (2) @(posedge clk);
      #1;
      check("reset_pulses", 32'(pulses), 32'(P_NONE));
      check("reset_busy", 32'(busy), 32'd1 - 32'd1);
      @(negedge clk);
      rst = 1'b0;

      // 1: async reset while a pulse is high, then fresh anchor
      send(500, 400, 1000);
      check("t1_anchor_busy", 32'(busy), 32'd1);
      send(550, 400, 1000);
      check("t1_no_pulse", 32'(pulses), 32'(P_NONE));
      send(800, 400, 1000);
      check("t1_right", 32'(pulses), 32'(P_RIGHT));
      #1 rst = 1'b1;
      #1;
      check("t1_rst_pulses", 32'(pulses), 32'(P_NONE));
      check("t1_rst_busy", 32'(busy), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      send(300, 300, 1000);
      check("t1_reanchor_busy", 32'(busy), 32'd1);
      check("t1_reanchor_pulse", 32'(pulses), 32'(P_NONE));
      send(520, 300, 1000);
      check("t1_right_after_rst", 32'(pulses), 32'(P_RIGHT));
      wait_idle(n, seen);
      check("t1_idle", 32'(busy), 32'd0);

      // 2: gradual right swipe, cooldown length
      send(500, 400, 1000);
      send(550, 400, 1000);
      check("t2_550", 32'(pulses), 32'(P_NONE));
      send(650, 400, 1000);
      check("t2_650", 32'(pulses), 32'(P_NONE));
      send(720, 400, 1000);
      check("t2_right", 32'(pulses), 32'(P_RIGHT));
      wait_idle(n, seen);
      check("t2_busy_cycles", 32'(n), 32'd16);
      check("t2_no_extra_pulse", 32'(seen), 32'(P_NONE));

      // 3: up swipe, then diagonal tie resolves horizontal
      send(500, 400, 1000);
      send(500, 150, 1000);
      check("t3_up", 32'(pulses), 32'(P_UP));
      wait_idle(n, seen);
      check("t3_idle1", 32'(busy), 32'd0);
      send(510, 400, 1000);
      send(260, 650, 1000);
      check("t3_tie_left", 32'(pulses), 32'(P_LEFT));
      wait_idle(n, seen);
      check("t3_idle2", 32'(busy), 32'd0);

      // 4: slow drift re-anchors after the window
      send(100, 100, 1000);
      for (int i = 1; i <= 7; i++) begin
         send(100 + 20 * i, 100, 1000);
         check($sformatf("t4_drift_%0d", i), 32'(pulses), 32'(P_NONE));
      end
      check("t4_still_busy", 32'(busy), 32'd1);
      send(430, 100, 1000);
      check("t4_dx190", 32'(pulses), 32'(P_NONE));
      send(450, 100, 1000);
      check("t4_right_dx210", 32'(pulses), 32'(P_RIGHT));
      wait_idle(n, seen);
      check("t4_idle", 32'(busy), 32'd0);

      // 5: samples during cooldown are ignored, then down swipe
      send(100, 100, 1000);
      send(100, 400, 1000);
      check("t5_down1", 32'(pulses), 32'(P_DOWN));
      send(0, 0, 1000);
      check("t5_cd_sample1", 32'(pulses), 32'(P_NONE));
      send(1000, 1000, 1000);
      check("t5_cd_sample2", 32'(pulses), 32'(P_NONE));
      wait_idle(n, seen);
      check("t5_cd_quiet", 32'(seen), 32'(P_NONE));
      check("t5_idle", 32'(busy), 32'd0);
      send(500, 500, 1000);
      check("t5_anchor", 32'(pulses), 32'(P_NONE));
      send(500, 720, 1000);
      check("t5_down2", 32'(pulses), 32'(P_DOWN));
      wait_idle(n, seen);

      // threshold boundary: 199 misses, 200 fires
      send(1000, 1000, 1000);
      send(1199, 1000, 1000);
      check("thr_199", 32'(pulses), 32'(P_NONE));
      send(1200, 1000, 1000);
      check("thr_200", 32'(pulses), 32'(P_RIGHT));
      wait_idle(n, seen);
      check("thr_idle", 32'(busy), 32'd0);

      // 6: far-depth sample
      send(600, 400, 1000);
      send(900, 400, 5000);
`ifdef DEPTH_GATE_EN
      check("t6_gate_pulse", 32'(pulses), 32'(P_NONE));
      check("t6_gate_busy", 32'(busy), 32'd0);
      send(600, 400, 5000);
      check("t6_gate_no_anchor", 32'(busy), 32'd0);
`else
      check("t6_right", 32'(pulses), 32'(P_RIGHT));
      wait_idle(n, seen);
      check("t6_idle", 32'(busy), 32'd0);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
